// File: rtl/stack_ctrl_pkg.sv
// Shared constants and types for the return-address stack controller.
package stack_ctrl_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DEPTH = 8;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/stack_ctrl_mem.sv
// DEPTH x WIDTH storage for the return-address stack: synchronous write,
// registered read that reads as zero in any cycle without a read.
module stack_mem
    import stack_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the array is deliberately left without reset so it maps onto plain
    // storage; only the read register below carries a reset value.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stack_ctrl.sv
// Return-address stack controller with two-port round-robin arbitration.
// Define STACK_CTRL_WRAP_EN to make push-when-full overwrite the oldest entry.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_op,
    input  logic [WIDTH-1:0]         req_data0,
    input  logic [WIDTH-1:0]         req_data1,
    output logic [1:0]               req_ready,
    output logic [1:0]               rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef STACK_CTRL_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    state_t          r_state;
    logic [AW-1:0]   r_top;
    logic [CW-1:0]   r_count;
    logic            r_last_grant;
    logic [1:0]      r_rsp_valid;
    logic            r_rsp_err;

    logic [1:0]      w_grant;
    logic            w_hs;
    logic            w_sel;
    logic            w_op;
    logic [WIDTH-1:0] w_data;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_err;
    logic [AW-1:0]   w_pop_addr;
    logic            w_suppress;
    logic [WIDTH-1:0] w_rd_data;

    // NOTE: w_grant gets a default before any branch so no latch is inferred.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE && !flush && !rst) begin
            if (req_valid == 2'b11) begin
                w_grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
                w_grant = req_valid;
            end
        end
    end

    assign w_hs       = |w_grant;
    assign w_sel      = w_grant[1];
    assign w_op       = req_op[w_sel];
    assign w_data     = w_sel ? req_data1 : req_data0;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_ok  = w_hs && (w_op == OP_PUSH) && (!w_full || WRAP_EN);
    assign w_pop_ok   = w_hs && (w_op == OP_POP) && !w_empty;
    assign w_err      = w_hs && !w_push_ok && !w_pop_ok;
    assign w_pop_addr = r_top - AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_top        <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_top       <= '0;
            r_count     <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            if (r_state == IDLE) begin
                if (w_hs) begin
                    r_state      <= RESP;
                    r_last_grant <= w_sel;
                    r_rsp_valid  <= w_grant;
                    r_rsp_err    <= w_err;
                    if (w_push_ok) begin
                        // A wrapping push on a full stack overwrites the oldest entry.
                        r_top <= r_top + AW'(1);
                        if (!w_full) begin
                            r_count <= r_count + CW'(1);
                        end
                    end else if (w_pop_ok) begin
                        r_top   <= w_pop_addr;
                        r_count <= r_count - CW'(1);
                    end
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_top),
        .i_wr_data (w_data),
        .i_rd_en   (w_pop_ok),
        .i_rd_addr (w_pop_addr),
        .o_rd_data (w_rd_data)
    );

    // A flush or reset landing on the response cycle kills the pulse.
    assign w_suppress = flush | rst;
    assign rsp_valid  = r_rsp_valid & {2{~w_suppress}};
    assign rsp_err    = r_rsp_err & ~w_suppress;
    assign rsp_data   = w_rd_data;
    assign req_ready  = w_grant;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Controller and two-port arbiter for the return-address stack. It owns an 8×12 LIFO storage array. It shares that array between requester 0 (datapath JAL/JR path) and requester 1 (exception/interrupt unit) using round-robin arbitration and a valid/ready handshake. It also provides full/empty/overflow/underflow detection and a flush.

## Interface
- WIDTH, 12, entry width (return address)
- DEPTH, 8, number of entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all entries and any pending response
- req_valid  input  2  per-requester request valid
- req_op  input  2  per-requester op: 1 = push, 0 = pop
- req_data0  input  WIDTH  push data, requester 0
- req_data1  input  WIDTH  push data, requester 1
- req_ready  output  2  one-hot grant; handshake when req_valid[i] & req_ready[i]
- rsp_valid  output  2  one-hot, response for the requester granted the previous cycle
- rsp_data  output  WIDTH  popped value; 0 for push or error
- rsp_err  output  1  overflow (push when full) or underflow (pop when empty)
- count  output  $clog2(DEPTH)+1  entries held
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RESP: issues the response; accepts no requests.
- Transitions:
  - IDLE→RESP on any handshake.
  - RESP→IDLE unconditionally.
  - flush forces IDLE from any state.
- Arbitration in IDLE (combinational req_ready):
  - Only one valid → grant it.
  - Both valid → grant the port not granted last.
  - last_grant updates only on a handshake.
  - req_ready = 0 in RESP, during flush, and during rst.
- Push, not full: mem[top] ← data; top ← top+1 (mod DEPTH); count+1; rsp_err=0.
- Push, full: storage, top and count unchanged; rsp_err=1.
- Pop, not empty: read mem[top-1]; top ← top-1; count-1; rsp_data = value.
- Pop, empty: no state change; rsp_err=1; rsp_data=0.
- Storage holds no reset value; only top, count, FSM, last_grant and outputs are reset.
- Flush: top=0, count=0. Any RESP in progress is suppressed, so rsp_valid=0 in that cycle. Takes priority over a simultaneous request.

## Timing
- Reset values:
  - req_ready=00, rsp_valid=00, rsp_data=0, rsp_err=0
  - count=0, full=0, empty=1
  - state IDLE, last_grant=1 (port 0 wins first tie)
- Latency: handshake in cycle N → rsp_valid/rsp_data/rsp_err registered, valid in cycle N+1 only (single-cycle pulse).
- Throughput: one operation per 2 cycles. Two back-to-back contending requesters alternate grants 0,1,0,1.
- count/full/empty are registered and reflect the operation from cycle N+1.
- Requesters hold req_valid/op/data stable until ready.
- rst asserted mid-operation: next cycle equals the reset state; the pending response is dropped.

## Configuration
- STACK_CTRL_WRAP_EN defined: push when full is accepted without error. It overwrites the oldest entry (circular), top advances mod DEPTH, count stays DEPTH, rsp_err=0. Underflow behaviour is unchanged.
- Not defined: overflow behaves as specified above (rejected, rsp_err=1).

## Structure
- Package stack_ctrl_pkg holds:
  - OP_PUSH/OP_POP constants
  - state typedef {IDLE, RESP}
  - default WIDTH/DEPTH constants
- Sub-module stack_mem: DEPTH×WIDTH register array with synchronous write and synchronous registered read. Its read port feeds rsp_data directly in cycle N+1.
- Arbiter, pointer/count logic and FSM live in stack_ctrl.

## Test plan
- Reset, then port 0 pushes 12'h001, 12'h002, then pops twice → rsp_data 12'h002 then 12'h001, rsp_err=0, count 2→0, empty=1.
- Both ports request in the same cycles (0 push 12'hA0A, 1 push 12'hB0B) → grants alternate 0,1,0,1, with port 0 first after reset, and rsp_valid is one-hot matching each grant.
- Pop on empty stack → rsp_err=1, rsp_data=0, count stays 0.
- 9 pushes of 1..9 without macro → 9th gives rsp_err=1 and full=1. With STACK_CTRL_WRAP_EN → rsp_err=0 and subsequent pops return 9,8,…,2.
- Push 3 entries, assert flush during RESP → rsp_valid=0 that cycle, count=0, empty=1, next pop gives rsp_err=1.
- Assert rst while a pop is pending → all outputs at reset values next cycle, no rsp_valid pulse.
